// File: rtl/spawn_scheduler.sv
// spawn_scheduler: turns LFSR bytes into spawn requests, one attempt per PERIOD clocks.
// Latency: entering WAIT_TICK with a free first sample -> o_spawn_valid high PERIOD+2 clocks later.
// Backpressure: the offer is held until i_spawn_ready; the tick timer is paused while offering.
// Ports:
//   i_clock, i_reset       clock, async active-high reset
//   i_start                level run request
//   i_rnd                  random byte from the LFSR
//   i_occupied             per-column blocked flags (sampled in CHECK)
//   o_rng_enable, o_busy   high whenever not IDLE (LFSR clears itself while disabled)
//   o_spawn_valid/_ready   spawn offer handshake, o_spawn_col/o_spawn_kind payload
//   o_drop_count           saturating count of ticks with no free column found
module spawn_scheduler #(
  parameter int NUM_COLS = 8,
  parameter int COL_W    = 3,
  parameter int PERIOD   = 1000000,
  parameter int CNT_W    = 20,
  parameter int MAX_TRY  = 4
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_start,
  input  logic [7:0]          i_rnd,
  input  logic [NUM_COLS-1:0] i_occupied,
  output logic                o_rng_enable,
  output logic                o_spawn_valid,
  input  logic                i_spawn_ready,
  output logic [COL_W-1:0]    o_spawn_col,
  output logic [1:0]          o_spawn_kind,
  output logic                o_busy,
  output logic [7:0]          o_drop_count
);

  localparam int TRY_W = $clog2(MAX_TRY + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SAMPLE,
    S_CHECK,
    S_OFFER
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_timer, w_timer_nxt;
  logic [TRY_W-1:0] r_try, w_try_nxt;
  logic [7:0]       r_sample, w_sample_nxt;
  logic [COL_W-1:0] r_spawn_col, w_spawn_col_nxt;
  logic [1:0]       r_spawn_kind, w_spawn_kind_nxt;
  logic [7:0]       r_drop_count, w_drop_count_nxt;

  // Column indices that do not exist on the playfield read as blocked, so a
  // single lookup covers both the range test and the occupancy test.
  logic [(1<<COL_W)-1:0] w_occ_pad;
  logic [COL_W-1:0]      w_col;
  logic                  w_col_free;

  always_comb begin
    w_occ_pad = '1;
    for (int c = 0; c < NUM_COLS; c++) begin
      w_occ_pad[c] = i_occupied[c];
    end
  end

  assign w_col      = r_sample[COL_W-1:0];
  assign w_col_free = ~w_occ_pad[w_col];

  // Only the column and kind fields of the sample are consumed.
  logic w_unused;
  assign w_unused = ^r_sample;

  always_comb begin
    w_state_nxt      = r_state;
    w_timer_nxt      = r_timer;
    w_try_nxt        = r_try;
    w_sample_nxt     = r_sample;
    w_spawn_col_nxt  = r_spawn_col;
    w_spawn_kind_nxt = r_spawn_kind;
    w_drop_count_nxt = r_drop_count;
    case (r_state)
      S_IDLE: begin
        w_timer_nxt = '0;
        if (i_start) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!i_start) begin
          w_state_nxt = S_IDLE;
          w_timer_nxt = '0;
          w_try_nxt   = '0;
        end else if (r_timer == CNT_W'(PERIOD - 1)) begin
          w_state_nxt = S_SAMPLE;
          w_timer_nxt = '0;
          w_try_nxt   = '0;
        end else begin
          w_timer_nxt = r_timer + 1'b1;
        end
      end
      S_SAMPLE: begin
        if (!i_start) begin
          w_state_nxt = S_IDLE;
          w_try_nxt   = '0;
        end else begin
          w_sample_nxt = i_rnd;
          w_try_nxt    = r_try + 1'b1;
          w_state_nxt  = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!i_start) begin
          w_state_nxt = S_IDLE;
          w_try_nxt   = '0;
        end else if (w_col_free) begin
          w_spawn_col_nxt  = w_col;
          w_spawn_kind_nxt = r_sample[7:6];
          w_state_nxt      = S_OFFER;
        end else if (r_try < TRY_W'(MAX_TRY)) begin
          // LFSR has moved on since the last sample, so retrying is meaningful.
          w_state_nxt = S_SAMPLE;
        end else begin
          if (r_drop_count != 8'hFF) w_drop_count_nxt = r_drop_count + 8'd1;
          w_state_nxt = S_WAIT;
          w_timer_nxt = '0;
        end
      end
      S_OFFER: begin
        // A deasserted start is honoured only after the pending offer is taken.
        if (i_spawn_ready) begin
          w_state_nxt = i_start ? S_WAIT : S_IDLE;
          w_timer_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_timer_nxt = '0;
        w_try_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_try        <= '0;
      r_sample     <= '0;
      r_spawn_col  <= '0;
      r_spawn_kind <= '0;
      r_drop_count <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_timer      <= w_timer_nxt;
      r_try        <= w_try_nxt;
      r_sample     <= w_sample_nxt;
      r_spawn_col  <= w_spawn_col_nxt;
      r_spawn_kind <= w_spawn_kind_nxt;
      r_drop_count <= w_drop_count_nxt;
    end
  end

  // Valid is decoded from the state register so an async reset drops it at once.
  assign o_spawn_valid = (r_state == S_OFFER);
  assign o_busy        = (r_state != S_IDLE);
  assign o_rng_enable  = (r_state != S_IDLE);
  assign o_spawn_col   = r_spawn_col;
  assign o_spawn_kind  = r_spawn_kind;
  assign o_drop_count  = r_drop_count;

endmodule

// File: tb/tb_spawn_scheduler.sv
// tb_spawn_scheduler: directed bench for spawn_scheduler with a queue of expected offers.
// Latency: offers are checked for exact cycle distance from entering the tick wait.
// Backpressure: the consumer ready is driven per step to exercise stalls and single transfers.
module tb_spawn_scheduler;
  localparam int NUM_COLS = 6;
  localparam int COL_W    = 3;
  localparam int PERIOD   = 4;
  localparam int CNT_W    = 3;
  localparam int MAX_TRY  = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [7:0]          rnd;
  logic [NUM_COLS-1:0] occ;
  logic                ready;
  logic                rng_en;
  logic                valid;
  logic [COL_W-1:0]    col;
  logic [1:0]          kind;
  logic                busy;
  logic [7:0]          drops;

  always #5 clk = ~clk;

  spawn_scheduler #(
    .NUM_COLS(NUM_COLS), .COL_W(COL_W), .PERIOD(PERIOD), .CNT_W(CNT_W), .MAX_TRY(MAX_TRY)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst),
    .i_start       (start),
    .i_rnd         (rnd),
    .i_occupied    (occ),
    .o_rng_enable  (rng_en),
    .o_spawn_valid (valid),
    .i_spawn_ready (ready),
    .o_spawn_col   (col),
    .o_spawn_kind  (kind),
    .o_busy        (busy),
    .o_drop_count  (drops)
  );

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  logic [4:0] exp_q[$];  // {col, kind}

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Wait (bounded) for an offer, check its latency, then pop and compare the payload.
  task automatic expect_offer(input string tag, input int lat);
    int k;
    logic [4:0] e;
    k = 0;
    while (valid !== 1'b1 && k < 40) begin
      step(1);
      k++;
    end
    chk({tag, "_lat"}, k, lat);
    chk({tag, "_queued"}, (exp_q.size() != 0), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk({tag, "_col"}, col, e[4:2]);
      chk({tag, "_kind"}, kind, e[1:0]);
    end
  endtask

  task automatic idle_cycles(input string tag, input int n);
    int seen;
    seen = 0;
    repeat (n) begin
      step(1);
      if (valid !== 1'b0) seen++;
    end
    chk(tag, seen, 0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    rnd   = 8'h00;
    occ   = '0;
    ready = 1'b0;
    step(2);
    chk("rst_valid", valid, 0);
    chk("rst_rng", rng_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_drops", drops, 0);
    chk("rst_col", col, 0);
    rst = 1'b0;
    step(1);
    chk("idle_rng", rng_en, 0);

    // Basic offers back to back.
    start = 1'b1; rnd = 8'hC3; occ = '0; ready = 1'b1;
    exp_q.push_back({3'd3, 2'd3});
    exp_q.push_back({3'd3, 2'd3});
    step(1);
    chk("start_rng", rng_en, 1);
    chk("start_busy", busy, 1);
    expect_offer("o1", 6);
    step(1);
    chk("o1_taken", valid, 0);
    expect_offer("o2", 6);

    // Retry: first sample hits occupied column 2, second sample picks column 5.
    rnd = 8'h02; occ = 6'b000100;
    exp_q.push_back({3'd5, 2'd1});
    step(1);
    chk("o2_taken", valid, 0);
    step(5);
    rnd = 8'h45;
    expect_offer("retry", 3);

    // Drops: column 7 never exists.
    rnd = 8'h07; occ = '0;
    step(1);
    chk("retry_taken", valid, 0);
    idle_cycles("drop1_nooffer", 11);
    chk("drop1_before", drops, 0);
    step(1);
    chk("drop1", drops, 1);
    for (int i = 2; i <= 256; i++) begin
      idle_cycles("drop_nooffer", 12);
      chk("drop_count", drops, (i > 255) ? 255 : i);
    end

    // Stalled consumer.
    ready = 1'b0; rnd = 8'h81;
    exp_q.push_back({3'd1, 2'd2});
    expect_offer("stall", 6);
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("stall_valid", valid, 1);
      chk("stall_col", col, 1);
      chk("stall_kind", kind, 2);
    end
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    chk("stall_taken", valid, 0);
    chk("drops_held", drops, 255);

    // start dropped during the tick wait.
    step(1);
    start = 1'b0;
    step(1);
    chk("stop_rng", rng_en, 0);
    chk("stop_busy", busy, 0);
    idle_cycles("stop_nooffer", 10);
    chk("stop_drops", drops, 255);

    // start dropped while an offer is pending.
    start = 1'b1; rnd = 8'hC3;
    exp_q.push_back({3'd3, 2'd3});
    step(1);
    expect_offer("offstop", 6);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("offstop_held", valid, 1);
    end
    ready = 1'b1;
    step(1);
    ready = 1'b0;
    chk("offstop_taken", valid, 0);
    chk("offstop_idle", busy, 0);

    // Async reset in the middle of an offer.
    start = 1'b1;
    exp_q.push_back({3'd3, 2'd3});
    step(1);
    expect_offer("arst", 6);
    chk("arst_pre_drops", drops, 255);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", valid, 0);
    chk("arst_drops", drops, 0);
    chk("arst_rng", rng_en, 0);
    step(1);
    rst = 1'b0;
    start = 1'b0;
    step(1);
    chk("post_arst_valid", valid, 0);
    chk("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/spawn_scheduler.md
Name: spawn_scheduler

Overview:
- Downstream consumer of the 8-bit LFSR random source; turns random bytes into game-object spawn requests.
- Every PERIOD clocks it samples the random byte and maps it to a free playfield column plus an object kind.
- It offers the result to the game-state logic over a valid/ready handshake.
- It drives the LFSR enable. The LFSR clears to 0 while disabled, so each run restarts the random sequence deterministically.

Parameters:
- NUM_COLS, 8: playfield columns, range 2..2^COL_W.
- COL_W, 3: column index width.
- PERIOD, 1000000: WAIT_TICK dwell in clocks, >= 2.
- CNT_W, 20: timer width; 2^CNT_W must be >= PERIOD.
- MAX_TRY, 4: random samples attempted per tick before dropping the tick.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  level run request; 1 = scheduling active.
- rnd  in  8  random byte from the LFSR output.
- occupied  in  NUM_COLS  bit c = 1 means column c is blocked; sampled in CHECK.
- rng_enable  out  1  LFSR enable.
- spawn_valid  out  1  spawn offer valid.
- spawn_ready  in  1  consumer accepts the offer.
- spawn_col  out  COL_W  column of the offered spawn.
- spawn_kind  out  2  object kind of the offered spawn.
- busy  out  1  1 when state is not IDLE.
- drop_count  out  8  ticks dropped for lack of a free column; saturating.

Behaviour:
- Reset (async): state=IDLE, timer=0, try=0, sample=0. All outputs 0, including drop_count.
- All outputs registered or decoded from the state register; no combinational path from any input to any output.
- rng_enable = busy = (state != IDLE).
- IDLE: timer=0. If start=1, go to WAIT_TICK next cycle.
- WAIT_TICK:
  - timer increments each cycle.
  - When timer == PERIOD-1: timer<=0, try<=0, go to SAMPLE.
  - Exactly PERIOD cycles are spent in WAIT_TICK.
- SAMPLE: sample<=rnd, try<=try+1, go to CHECK. One cycle.
- CHECK: col = sample[COL_W-1:0].
  - Column is free when col < NUM_COLS and occupied[col] = 0. Then spawn_col<=col, spawn_kind<=sample[7:6], go to OFFER.
  - Otherwise, if try < MAX_TRY, go to SAMPLE. The LFSR has advanced, so the new sample differs.
  - Otherwise drop_count<=drop_count+1 (holds at 255), go to WAIT_TICK with timer=0.
- OFFER:
  - spawn_valid=1; spawn_col and spawn_kind stay stable until the transfer.
  - Transfer occurs on a cycle with spawn_valid=1 and spawn_ready=1. Then spawn_valid<=0 and go to WAIT_TICK with timer=0.
  - spawn_valid is never withdrawn before a transfer. The timer does not run in OFFER, so a stalled consumer stretches the period.
  - spawn_ready while spawn_valid=0 is ignored.
- Latency: entering WAIT_TICK with a free first sample gives spawn_valid high PERIOD+2 cycles later.
- start deasserted:
  - In WAIT_TICK, SAMPLE or CHECK: go to IDLE next cycle. Timer and try cleared, no offer, no drop counted.
  - In OFFER: complete the handshake first, then go to IDLE instead of WAIT_TICK.
- Reset asserted mid-offer: spawn_valid drops immediately (async).
- drop_count only clears on reset; start toggling does not clear it.
- occupied all ones: every tick ends in a drop after exactly MAX_TRY SAMPLE/CHECK pairs.

Test Plan (bench drives rnd directly; PERIOD=4, MAX_TRY=4, NUM_COLS=6):
- Reset, then start=1, rnd=8'hC3, occupied=0, ready=1:
  - rng_enable=1 one cycle after start.
  - spawn_valid pulses 6 cycles after entering WAIT_TICK with col=3, kind=3.
  - The next offer follows 6 cycles after the transfer.
- rnd=8'h02, occupied=6'b000100 for the first sample, then rnd=8'h45 -> one retry, offer col=5, kind=1.
- rnd=8'h07 constant (col 7 >= NUM_COLS) -> no offer. drop_count increments by 1 per tick after 4 tries; force to 254 and confirm it holds at 255.
- Offer pending with ready=0 for 10 cycles -> valid, col and kind stable. Ready=1 for one cycle -> single transfer, valid low next cycle.
- start=0 in WAIT_TICK -> IDLE next cycle, rng_enable=0, no offer.
- start=0 during OFFER -> offer held until ready, then IDLE.
- Assert reset asynchronously mid-OFFER -> spawn_valid, drop_count and rng_enable go to 0 before the next clock edge.
